thread_register_file: RTL and testbench

Per-thread register file for the MiniGPU compute core, the parametrised successor of the single-thread 8-bit register file. It adds configurable data width and register count, read-only special registers, a load scoreboard for asynchronous LSU writeback with same-cycle bypass, and a hazard flag that lets the core scheduler stall dependent instructions. One instance sits beside each thread's ALU/LSU pair inside a core.

---
 rtl/gpu_pkg.sv | 28 ++
 rtl/regfile_scoreboard.sv | 43 ++++
 rtl/thread_register_file.sv | 122 ++++++++++++
 tb/tb_thread_register_file.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared MiniGPU core definitions: core FSM state codes, writeback source select
// codes and the offsets of the read-only special registers from the top of the file.
package gpu_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [1:0] {
        MUX_ALU  = 2'b00,
        MUX_LSU  = 2'b01,
        MUX_IMM  = 2'b10,
        MUX_NONE = 2'b11
    } reg_input_mux_t;

    // Special registers sit at NUM_REGS - offset.
    localparam int unsigned BID_OFFSET  = 3;
    localparam int unsigned BDIM_OFFSET = 2;
    localparam int unsigned TID_OFFSET  = 1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load bit per register: set by load issue, cleared by UPDATE writes or
// LSU writeback (set wins), plus hazard lookup on the post-clear pending vector.
module regfile_scoreboard #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned AW       = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          set_valid,
    input  logic [AW-1:0] set_index,
    input  logic          upd_clear_valid,
    input  logic [AW-1:0] upd_clear_index,
    input  logic          wb_clear_valid,
    input  logic [AW-1:0] wb_clear_index,
    input  logic [AW-1:0] rs_address,
    input  logic [AW-1:0] rt_address,
    output logic          hazard_lookup
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clear_mask;
    logic [NUM_REGS-1:0] cleared;

    always_comb begin
        set_mask   = '0;
        clear_mask = '0;
        if (set_valid)       set_mask[set_index]         = 1'b1;
        if (upd_clear_valid) clear_mask[upd_clear_index] = 1'b1;
        if (wb_clear_valid)  clear_mask[wb_clear_index]  = 1'b1;
        cleared       = pending & ~clear_mask;
        hazard_lookup = cleared[rs_address] | cleared[rt_address];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= cleared | set_mask;
        end
    end

endmodule

// File: rtl/thread_register_file.sv
// Per-thread register file: GP storage, block/thread special registers, operand
// read with LSU writeback bypass, and UPDATE/LSU writeback ports.
module thread_register_file #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned BLOCK_DIM  = 4,
    parameter int unsigned THREAD_ID  = 0,
    localparam int unsigned AW        = $clog2(NUM_REGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [2:0]            core_state,
    input  logic [DATA_WIDTH-1:0] block_id,
    input  logic [AW-1:0]         rs_address,
    input  logic [AW-1:0]         rt_address,
    input  logic [AW-1:0]         rd_address,
    input  logic                  reg_write_enable,
    input  logic [1:0]            reg_input_mux,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic [DATA_WIDTH-1:0] lsu_out,
    input  logic [DATA_WIDTH-1:0] immediate,
    input  logic                  load_issue,
    input  logic                  lsu_wb_valid,
    input  logic [AW-1:0]         lsu_wb_rd,
    input  logic [DATA_WIDTH-1:0] lsu_wb_data,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic [DATA_WIDTH-1:0] rt_data,
    output logic                  hazard,
    output logic                  write_error
);

    import gpu_pkg::*;

    localparam logic [AW-1:0] BID_IDX  = AW'(NUM_REGS - BID_OFFSET);
    localparam logic [AW-1:0] BDIM_IDX = AW'(NUM_REGS - BDIM_OFFSET);
    localparam logic [AW-1:0] TID_IDX  = AW'(NUM_REGS - TID_OFFSET);
    localparam logic [DATA_WIDTH-1:0] BDIM_VALUE = DATA_WIDTH'(BLOCK_DIM);
    localparam logic [DATA_WIDTH-1:0] TID_VALUE  = DATA_WIDTH'(THREAD_ID);

    function automatic logic is_gp(input logic [AW-1:0] idx);
        return idx < BID_IDX;
    endfunction

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    core_state_t           state;
    reg_input_mux_t        mux_sel;
    logic                  is_request;
    logic                  upd_write;
    logic                  rd_gp;
    logic                  wb_gp;
    logic                  wb_write;
    logic                  load_set;
    logic                  sb_hazard;
    logic [DATA_WIDTH-1:0] wb_src;
    logic [DATA_WIDTH-1:0] rs_value;
    logic [DATA_WIDTH-1:0] rt_value;

    always_comb begin
        state      = core_state_t'(core_state);
        mux_sel    = reg_input_mux_t'(reg_input_mux);
        is_request = enable && (state == CORE_REQUEST);
        upd_write  = enable && (state == CORE_UPDATE) && reg_write_enable && (mux_sel != MUX_NONE);
        rd_gp      = is_gp(rd_address);
        wb_gp      = is_gp(lsu_wb_rd);
        wb_write   = lsu_wb_valid && wb_gp;
        load_set   = enable && load_issue && rd_gp;

        unique case (mux_sel)
            MUX_ALU: wb_src = alu_out;
            MUX_LSU: wb_src = lsu_out;
            MUX_IMM: wb_src = immediate;
            default: wb_src = '0;
        endcase

        // Returning load data is forwarded straight into the operand latch.
        rs_value = (wb_write && (lsu_wb_rd == rs_address)) ? lsu_wb_data : regs[rs_address];
        rt_value = (wb_write && (lsu_wb_rd == rt_address)) ? lsu_wb_data : regs[rt_address];
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_scoreboard (
        .clock           (clock),
        .reset           (reset),
        .set_valid       (load_set),
        .set_index       (rd_address),
        .upd_clear_valid (upd_write && rd_gp),
        .upd_clear_index (rd_address),
        .wb_clear_valid  (wb_write),
        .wb_clear_index  (lsu_wb_rd),
        .rs_address      (rs_address),
        .rt_address      (rt_address),
        .hazard_lookup   (sb_hazard)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            regs           <= '{default: '0};
            regs[BDIM_IDX] <= BDIM_VALUE;
            regs[TID_IDX]  <= TID_VALUE;
            rs_data        <= '0;
            rt_data        <= '0;
            hazard         <= 1'b0;
            write_error    <= 1'b0;
        end else begin
            // Later assignment wins: UPDATE overrides LSU writeback to the same register.
            if (wb_write) regs[lsu_wb_rd] <= lsu_wb_data;
            if (upd_write && rd_gp) regs[rd_address] <= wb_src;
            if (enable) regs[BID_IDX] <= block_id;
            if (is_request) begin
                rs_data <= rs_value;
                rt_data <= rt_value;
                hazard  <= sb_hazard;
            end
            write_error <= enable && ((upd_write && !rd_gp) || (lsu_wb_valid && !wb_gp));
        end
    end

endmodule

// File: tb/tb_thread_register_file.sv
// Bench for thread_register_file: directed and random cycles against a small
// reference model; REQUEST results are queued and compared when they appear.
module tb_thread_register_file;

    import gpu_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic [7:0] block_id;
    logic [3:0] rs_address, rt_address, rd_address;
    logic       reg_write_enable;
    logic [1:0] reg_input_mux;
    logic [7:0] alu_out, lsu_out, immediate;
    logic       load_issue, lsu_wb_valid;
    logic [3:0] lsu_wb_rd;
    logic [7:0] lsu_wb_data;
    logic [7:0] rs_data, rt_data;
    logic       hazard, write_error;

    thread_register_file #(
        .DATA_WIDTH (8),
        .NUM_REGS   (16),
        .BLOCK_DIM  (4),
        .THREAD_ID  (2)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .core_state       (core_state),
        .block_id         (block_id),
        .rs_address       (rs_address),
        .rt_address       (rt_address),
        .rd_address       (rd_address),
        .reg_write_enable (reg_write_enable),
        .reg_input_mux    (reg_input_mux),
        .alu_out          (alu_out),
        .lsu_out          (lsu_out),
        .immediate        (immediate),
        .load_issue       (load_issue),
        .lsu_wb_valid     (lsu_wb_valid),
        .lsu_wb_rd        (lsu_wb_rd),
        .lsu_wb_data      (lsu_wb_data),
        .rs_data          (rs_data),
        .rt_data          (rt_data),
        .hazard           (hazard),
        .write_error      (write_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int       due;
        logic [7:0] rs;
        logic [7:0] rt;
        logic       hz;
    } exp_t;

    exp_t        exp_q[$];
    int          cycle = 0;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mregs [16];
    logic [15:0] mpend;
    logic [7:0]  mlast_rs, mlast_rt;
    logic        mlast_hz;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic logic is_gp(input logic [3:0] i);
        return i < 4'd13;
    endfunction

    function automatic logic [7:0] model_read(input logic [3:0] i);
        if (i == 4'd14) return 8'd4;
        if (i == 4'd15) return 8'd2;
        return mregs[i];
    endfunction

    always @(negedge clock) begin : monitor
        exp_t e;
        if (exp_q.size() != 0 && exp_q[0].due == cycle) begin
            e = exp_q.pop_front();
            check_eq("rs_data", 32'(rs_data), 32'(e.rs));
            check_eq("rt_data", 32'(rt_data), 32'(e.rt));
            check_eq("hazard", 32'(hazard), 32'(e.hz));
        end
    end

    task automatic drive_idle();
        enable = 1'b1; core_state = CORE_IDLE;
        rs_address = '0; rt_address = '0; rd_address = '0;
        reg_write_enable = 1'b0; reg_input_mux = MUX_NONE;
        alu_out = '0; lsu_out = '0; immediate = '0;
        load_issue = 1'b0; lsu_wb_valid = 1'b0; lsu_wb_rd = '0; lsu_wb_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        foreach (mregs[i]) mregs[i] = '0;
        mpend = '0;
        mlast_rs = '0; mlast_rt = '0; mlast_hz = 1'b0;
        check_eq("reset_rs", 32'(rs_data), 32'h0);
        check_eq("reset_rt", 32'(rt_data), 32'h0);
        check_eq("reset_hazard", 32'(hazard), 32'h0);
        check_eq("reset_write_error", 32'(write_error), 32'h0);
    endtask

    // One clock cycle of stimulus; the model advances alongside it.
    task automatic step(input logic en, input logic [2:0] st, input logic [3:0] rs,
                        input logic [3:0] rt, input logic [3:0] rd, input logic we,
                        input logic [1:0] mux, input logic [7:0] alu, input logic [7:0] lsu,
                        input logic [7:0] imm, input logic ld, input logic wbv,
                        input logic [3:0] wbrd, input logic [7:0] wbd);
        logic        upd, exp_we, req;
        logic [7:0]  sel;
        logic [15:0] cl;
        exp_t        e;
        enable = en; core_state = st; rs_address = rs; rt_address = rt; rd_address = rd;
        reg_write_enable = we; reg_input_mux = mux; alu_out = alu; lsu_out = lsu;
        immediate = imm; load_issue = ld; lsu_wb_valid = wbv; lsu_wb_rd = wbrd;
        lsu_wb_data = wbd;

        req = en && (st == CORE_REQUEST);
        if (req) begin
            cl = mpend;
            if (wbv && is_gp(wbrd)) cl[wbrd] = 1'b0;
            e.due = cycle + 1;
            e.rs  = (wbv && is_gp(wbrd) && wbrd == rs) ? wbd : model_read(rs);
            e.rt  = (wbv && is_gp(wbrd) && wbrd == rt) ? wbd : model_read(rt);
            e.hz  = cl[rs] | cl[rt];
            exp_q.push_back(e);
            mlast_rs = e.rs; mlast_rt = e.rt; mlast_hz = e.hz;
        end
        upd = en && (st == CORE_UPDATE) && we && (mux != 2'b11);
        case (mux)
            2'b00:   sel = alu;
            2'b01:   sel = lsu;
            default: sel = imm;
        endcase
        exp_we = en && ((upd && !is_gp(rd)) || (wbv && !is_gp(wbrd)));
        if (wbv && is_gp(wbrd)) begin mregs[wbrd] = wbd; mpend[wbrd] = 1'b0; end
        if (upd && is_gp(rd))   begin mregs[rd] = sel;   mpend[rd] = 1'b0;   end
        if (ld && en && is_gp(rd)) mpend[rd] = 1'b1;
        if (en) mregs[13] = block_id;

        @(negedge clock);
        check_eq("write_error", 32'(write_error), 32'(exp_we));
        if (!req) begin
            check_eq("hold_rs", 32'(rs_data), 32'(mlast_rs));
            check_eq("hold_rt", 32'(rt_data), 32'(mlast_rt));
            check_eq("hold_hazard", 32'(hazard), 32'(mlast_hz));
        end
    endtask

    task automatic req(input logic [3:0] rs, input logic [3:0] rt);
        step(1'b1, CORE_REQUEST, rs, rt, 4'd0, 1'b0, MUX_NONE, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0, 4'd0, 8'h0);
    endtask

    task automatic req_wb(input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] wbrd, input logic [7:0] wbd);
        step(1'b1, CORE_REQUEST, rs, rt, 4'd0, 1'b0, MUX_NONE, 8'h0, 8'h0, 8'h0, 1'b0, 1'b1, wbrd, wbd);
    endtask

    task automatic upd(input logic [3:0] rd, input logic [1:0] mux, input logic [7:0] val);
        step(1'b1, CORE_UPDATE, 4'd0, 4'd0, rd, 1'b1, mux,
             (mux == 2'b00) ? val : 8'hC3, (mux == 2'b01) ? val : 8'h3C,
             (mux == 2'b10) ? val : 8'hF0, 1'b0, 1'b0, 4'd0, 8'h0);
    endtask

    task automatic ld(input logic [3:0] rd);
        step(1'b1, CORE_EXECUTE, 4'd0, 4'd0, rd, 1'b0, MUX_NONE, 8'h0, 8'h0, 8'h0, 1'b1, 1'b0, 4'd0, 8'h0);
    endtask

    task automatic wb(input logic en, input logic [3:0] rd, input logic [7:0] d);
        step(en, CORE_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, MUX_NONE, 8'h0, 8'h0, 8'h0, 1'b0, 1'b1, rd, d);
    endtask

    task automatic idle();
        step(1'b1, CORE_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, MUX_NONE, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0, 4'd0, 8'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        block_id = 8'd7;
        do_reset();

        req(4'd14, 4'd15);                 // constants 4 and 2
        upd(4'd3, MUX_IMM, 8'h5A);
        req(4'd3, 4'd0);
        upd(4'd3, MUX_NONE, 8'h77);        // no write
        req(4'd3, 4'd3);

        upd(4'd13, MUX_ALU, 8'h99);        // special target: write_error pulse
        idle();
        req(4'd13, 4'd14);

        ld(4'd5);
        req(4'd5, 4'd0);
        req_wb(4'd5, 4'd1, 4'd5, 8'h33);
        req(4'd5, 4'd5);

        ld(4'd6);
        step(1'b1, CORE_UPDATE, 4'd0, 4'd0, 4'd6, 1'b1, MUX_ALU, 8'h11, 8'h3C, 8'hF0,
             1'b0, 1'b1, 4'd6, 8'h22);
        req(4'd6, 4'd6);

        ld(4'd7);
        wb(1'b0, 4'd7, 8'h44);
        step(1'b0, CORE_REQUEST, 4'd7, 4'd7, 4'd0, 1'b0, MUX_NONE, 8'h0, 8'h0, 8'h0,
             1'b0, 1'b0, 4'd0, 8'h0);
        req(4'd7, 4'd7);

        ld(4'd8);
        ld(4'd9);
        do_reset();
        req(4'd8, 4'd9);
        wb(1'b1, 4'd8, 8'h55);
        req(4'd8, 4'd9);

        ld(4'd15);
        req(4'd15, 4'd15);
        wb(1'b1, 4'd14, 8'hEE);
        req(4'd14, 4'd13);
        step(1'b1, CORE_EXECUTE, 4'd0, 4'd0, 4'd10, 1'b0, MUX_NONE, 8'h0, 8'h0, 8'h0,
             1'b1, 1'b1, 4'd10, 8'h66);
        req(4'd10, 4'd0);
        wb(1'b1, 4'd10, 8'h67);
        req(4'd10, 4'd10);

        for (int n = 0; n < 60; n++) begin
            logic [2:0] st;
            case ($urandom_range(3, 0))
                0:       st = CORE_REQUEST;
                1:       st = CORE_UPDATE;
                2:       st = CORE_EXECUTE;
                default: st = CORE_IDLE;
            endcase
            block_id = 8'($urandom_range(255, 0));
            step(($urandom_range(9, 0) != 0), st, 4'($urandom_range(15, 0)),
                 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
                 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                 8'($urandom_range(255, 0)), ($urandom_range(2, 0) == 0),
                 ($urandom_range(2, 0) == 0), 4'($urandom_range(15, 0)),
                 8'($urandom_range(255, 0)));
        end
        idle();

        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clock);
        if (exp_q.size() != 0) check_eq("drain", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
